// File: rtl/cpu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_pkg : shared fetch-path widths and the {pc, inst} packet type. Rev 1.0
// ----------------------------------------------------------------------------
package cpu_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_pkt_t;
endpackage
`default_nettype wire

// File: rtl/fetch_queue_mem.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_queue_mem : DEPTH-entry packet array, sync write / comb read. Rev 1.0
// ----------------------------------------------------------------------------
module fetch_queue_mem
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  fetch_pkt_t       i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output fetch_pkt_t       o_rdata
);

  fetch_pkt_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_queue : IF->ID decoupling FIFO with EX redirect flush. Rev 1.0
// ----------------------------------------------------------------------------
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [ILEN-1:0]  if_inst,
  output logic             if_stall,
  output logic             if_pc_src,
  output logic [XLEN-1:0]  if_b_j_result,
  input  logic             ex_redirect,
  input  logic [XLEN-1:0]  ex_target,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [XLEN-1:0]  id_pc,
  output logic [ILEN-1:0]  id_inst,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_warm;
  logic             r_primed;
  logic [CNT_W-1:0] r_flush_cnt;

  logic       w_full;
  logic       w_empty;
  logic       w_enq;
  logic       w_deq;
  fetch_pkt_t w_wdata;
  fetch_pkt_t w_head;

  assign w_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_enq   = r_warm & ~w_full & ~ex_redirect;
  assign w_deq   = id_valid & id_ready & ~ex_redirect;

  assign if_stall      = w_full & ~ex_redirect;
  assign if_pc_src     = ex_redirect;
  assign if_b_j_result = ex_target;

  assign id_valid  = ~w_empty;
  assign flush_cnt = r_flush_cnt;

  // Array is unreset; mask its contents until the first entry has been written.
  assign id_pc   = r_primed ? w_head.pc   : '0;
  assign id_inst = r_primed ? w_head.inst : '0;

  assign w_wdata.pc   = if_pc;
  assign w_wdata.inst = if_inst;

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_enq),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_warm      <= 1'b0;
      r_primed    <= 1'b0;
      r_flush_cnt <= '0;
    end else begin
      r_warm <= 1'b1;
      if (ex_redirect) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
        if (~&r_flush_cnt) r_flush_cnt <= r_flush_cnt + 1'b1;
      end else begin
        if (w_enq) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          r_primed <= 1'b1;
        end
        if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count <= r_count + (PTR_W+1)'(w_enq) - (PTR_W+1)'(w_deq);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fetch_queue : directed self-checking bench with a simple IF PC model. Rev 1.0
// ----------------------------------------------------------------------------
module tb_fetch_queue;
  localparam int CNT_W = 2;

  logic             clk;
  logic             reset;
  logic [63:0]      if_pc;
  logic [31:0]      if_inst;
  logic             if_stall;
  logic             if_pc_src;
  logic [63:0]      if_b_j_result;
  logic             ex_redirect;
  logic [63:0]      ex_target;
  logic             id_valid;
  logic             id_ready;
  logic [63:0]      id_pc;
  logic [31:0]      id_inst;
  logic [CNT_W-1:0] flush_cnt;

  int ncmp = 0;
  int nerr = 0;
  logic [63:0] acc[$];

  fetch_queue #(.DEPTH(4), .PTR_W(2), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .if_stall      (if_stall),
    .if_pc_src     (if_pc_src),
    .if_b_j_result (if_b_j_result),
    .ex_redirect   (ex_redirect),
    .ex_target     (ex_target),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_pc         (id_pc),
    .id_inst       (id_inst),
    .flush_cnt     (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [63:0] pc);
    return pc[31:0] ^ 32'h0BAD_F00D;
  endfunction

  // One clock of the IF model: hold PC on stall, jump on redirect, else +4.
  task automatic tick();
    logic st, rd;
    logic [63:0] tg;
    st = if_stall;
    rd = ex_redirect;
    tg = ex_target;
    if (id_valid && id_ready && !ex_redirect) acc.push_back(id_pc);
    @(posedge clk);
    #1;
    if (rd) if_pc = tg;
    else if (!st) if_pc = if_pc + 64'd4;
    if_inst = inst_of(if_pc);
    #1;
  endtask

  task automatic do_release();
    @(posedge clk);
    #1;
    reset   = 1'b0;
    if_pc   = 64'h0;
    if_inst = inst_of(64'h0);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; ex_redirect = 1'b0; ex_target = '0; id_ready = 1'b0;
    if_pc = 64'h0; if_inst = inst_of(64'h0);
    repeat (2) @(posedge clk);
    #1;
    ncmp++; if (id_valid !== 1'b0)  begin nerr++; $display("FAIL rst_valid got %b want 0", id_valid); end
    ncmp++; if (if_stall !== 1'b0)  begin nerr++; $display("FAIL rst_stall got %b want 0", if_stall); end
    ncmp++; if (if_pc_src !== 1'b0) begin nerr++; $display("FAIL rst_pcsrc got %b want 0", if_pc_src); end
    ncmp++; if (id_pc !== 64'h0)    begin nerr++; $display("FAIL rst_idpc got %h want 0", id_pc); end
    ncmp++; if (id_inst !== 32'h0)  begin nerr++; $display("FAIL rst_idinst got %h want 0", id_inst); end
    ncmp++; if (flush_cnt !== '0)   begin nerr++; $display("FAIL rst_fcnt got %0d want 0", flush_cnt); end
  endtask

  task automatic test_warmup(input string tag);
    do_release();
    ncmp++; if (id_valid !== 1'b0) begin nerr++; $display("FAIL %s_c1_valid got %b want 0", tag, id_valid); end
    tick();
    ncmp++; if (id_valid !== 1'b0) begin nerr++; $display("FAIL %s_c2_valid got %b want 0", tag, id_valid); end
    tick();
    ncmp++; if (id_valid !== 1'b1)  begin nerr++; $display("FAIL %s_c3_valid got %b want 1", tag, id_valid); end
    ncmp++; if (id_pc !== 64'h4)    begin nerr++; $display("FAIL %s_c3_pc got %h want 4", tag, id_pc); end
    ncmp++; if (id_inst !== inst_of(64'h4)) begin nerr++; $display("FAIL %s_c3_inst got %h want %h", tag, id_inst, inst_of(64'h4)); end
    ncmp++; if (flush_cnt !== '0)   begin nerr++; $display("FAIL %s_fcnt got %0d want 0", tag, flush_cnt); end
  endtask

  task automatic test_fill();
    id_ready = 1'b0;
    tick(); tick();
    ncmp++; if (if_stall !== 1'b0) begin nerr++; $display("FAIL fill_cnt3_stall got %b want 0", if_stall); end
    tick();
    ncmp++; if (if_stall !== 1'b1) begin nerr++; $display("FAIL fill_full_stall got %b want 1", if_stall); end
    ncmp++; if (id_pc !== 64'h4)   begin nerr++; $display("FAIL fill_head got %h want 4", id_pc); end
    tick();
    ncmp++; if (if_stall !== 1'b1) begin nerr++; $display("FAIL fill_hold_stall got %b want 1", if_stall); end
    ncmp++; if (id_pc !== 64'h4)   begin nerr++; $display("FAIL fill_hold_head got %h want 4", id_pc); end
  endtask

  task automatic test_drain_full();
    acc.delete();
    id_ready = 1'b1;
    #1;
    ncmp++; if (if_stall !== 1'b1) begin nerr++; $display("FAIL drain_same_stall got %b want 1", if_stall); end
    tick();
    id_ready = 1'b0;
    #1;
    ncmp++; if (id_pc !== 64'h8)   begin nerr++; $display("FAIL drain_head got %h want 8", id_pc); end
    ncmp++; if (if_stall !== 1'b0) begin nerr++; $display("FAIL drain_cnt3_stall got %b want 0", if_stall); end
    tick();
    ncmp++; if (if_stall !== 1'b1) begin nerr++; $display("FAIL drain_refill_stall got %b want 1", if_stall); end
    id_ready = 1'b1;
    repeat (4) tick();
    ncmp++; if (acc.size() != 5) begin nerr++; $display("FAIL drain_order_n got %0d want 5", acc.size()); end
    for (int i = 0; i < 5 && i < acc.size(); i++) begin
      ncmp++;
      if (acc[i] !== 64'h4 * (i + 1)) begin
        nerr++; $display("FAIL drain_order[%0d] got %h want %h", i, acc[i], 64'h4 * (i + 1));
      end
    end
    id_ready = 1'b0;
    tick();
  endtask

  task automatic test_redirect_full();
    ncmp++; if (if_stall !== 1'b1) begin nerr++; $display("FAIL redir_pre_full got %b want 1", if_stall); end
    id_ready = 1'b1; ex_redirect = 1'b1; ex_target = 64'h200;
    #1;
    ncmp++; if (if_stall !== 1'b0)       begin nerr++; $display("FAIL redir_stall got %b want 0", if_stall); end
    ncmp++; if (if_pc_src !== 1'b1)      begin nerr++; $display("FAIL redir_pcsrc got %b want 1", if_pc_src); end
    ncmp++; if (if_b_j_result !== 64'h200) begin nerr++; $display("FAIL redir_bj got %h want 200", if_b_j_result); end
    acc.delete();
    tick();
    ex_redirect = 1'b0;
    #1;
    ncmp++; if (id_valid !== 1'b0)  begin nerr++; $display("FAIL redir_n1_valid got %b want 0", id_valid); end
    ncmp++; if (flush_cnt !== 2'd1) begin nerr++; $display("FAIL redir_fcnt got %0d want 1", flush_cnt); end
    ncmp++; if (if_pc_src !== 1'b0) begin nerr++; $display("FAIL redir_pcsrc_off got %b want 0", if_pc_src); end
    ncmp++; if (acc.size() != 0)    begin nerr++; $display("FAIL redir_no_deq got %0d want 0", acc.size()); end
    tick();
    ncmp++; if (id_valid !== 1'b1)  begin nerr++; $display("FAIL redir_n2_valid got %b want 1", id_valid); end
    ncmp++; if (id_pc !== 64'h200)  begin nerr++; $display("FAIL redir_n2_pc got %h want 200", id_pc); end
  endtask

  task automatic test_back_to_back();
    ex_redirect = 1'b1; ex_target = 64'h300;
    #1;
    tick();
    ex_target = 64'h400;
    #1;
    ncmp++; if (if_pc_src !== 1'b1)        begin nerr++; $display("FAIL b2b_pcsrc got %b want 1", if_pc_src); end
    ncmp++; if (if_b_j_result !== 64'h400) begin nerr++; $display("FAIL b2b_bj got %h want 400", if_b_j_result); end
    ncmp++; if (id_valid !== 1'b0)         begin nerr++; $display("FAIL b2b_valid1 got %b want 0", id_valid); end
    ncmp++; if (flush_cnt !== 2'd2)        begin nerr++; $display("FAIL b2b_fcnt2 got %0d want 2", flush_cnt); end
    tick();
    ex_redirect = 1'b0;
    #1;
    ncmp++; if (id_valid !== 1'b0)  begin nerr++; $display("FAIL b2b_valid2 got %b want 0", id_valid); end
    ncmp++; if (flush_cnt !== 2'd3) begin nerr++; $display("FAIL b2b_fcnt3 got %0d want 3", flush_cnt); end
    tick();
    ncmp++; if (id_valid !== 1'b1)  begin nerr++; $display("FAIL b2b_valid3 got %b want 1", id_valid); end
    ncmp++; if (id_pc !== 64'h400)  begin nerr++; $display("FAIL b2b_pc got %h want 400", id_pc); end
  endtask

  task automatic test_wrap();
    id_ready = 1'b0; ex_redirect = 1'b1; ex_target = 64'h1000;
    #1;
    tick();
    ex_redirect = 1'b0;
    #1;
    ncmp++; if (flush_cnt !== 2'd3) begin nerr++; $display("FAIL wrap_fcnt_sat got %0d want 3", flush_cnt); end
    acc.delete();
    for (int c = 0; c < 200 && acc.size() < 10; c++) begin
      id_ready = (c % 2 == 0);
      #1;
      tick();
    end
    ncmp++; if (acc.size() < 10) begin nerr++; $display("FAIL wrap_timeout got %0d want 10 entries", acc.size()); end
    for (int i = 0; i < 10 && i < acc.size(); i++) begin
      ncmp++;
      if (acc[i] !== 64'h1000 + 64'h4 * i) begin
        nerr++; $display("FAIL wrap[%0d] got %h want %h", i, acc[i], 64'h1000 + 64'h4 * i);
      end
    end
  endtask

  task automatic test_async_reset();
    id_ready = 1'b0; ex_redirect = 1'b1; ex_target = 64'h2000;
    #1;
    tick();
    ex_redirect = 1'b0;
    #1;
    repeat (3) tick();
    ncmp++; if (id_valid !== 1'b1)   begin nerr++; $display("FAIL ar_pre_valid got %b want 1", id_valid); end
    ncmp++; if (id_pc !== 64'h2000)  begin nerr++; $display("FAIL ar_pre_pc got %h want 2000", id_pc); end
    #2;
    reset = 1'b1;
    #1;
    ncmp++; if (id_valid !== 1'b0)  begin nerr++; $display("FAIL ar_valid got %b want 0", id_valid); end
    ncmp++; if (if_stall !== 1'b0)  begin nerr++; $display("FAIL ar_stall got %b want 0", if_stall); end
    ncmp++; if (id_pc !== 64'h0)    begin nerr++; $display("FAIL ar_idpc got %h want 0", id_pc); end
    ncmp++; if (flush_cnt !== '0)   begin nerr++; $display("FAIL ar_fcnt got %0d want 0", flush_cnt); end
    if_pc = 64'h0; if_inst = inst_of(64'h0);
    @(posedge clk);
    test_warmup("ar_warm");
  endtask

  initial begin
    test_reset();
    test_warmup("warm");
    test_fill();
    test_drain_full();
    test_redirect_full();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Receiving end of the fetch-stage output interface. Captures {pc_current, inst} pairs from IF into a small FIFO and presents them to ID with a valid/ready handshake.
- Drives IF's stall input when the queue is full.
- Drives IF's pc_src/b_j_Result from the redirect request raised in EX, and flushes all wrong-path entries on that redirect.
- Sits between IF and ID; replaces a plain IF/ID register so ID back-pressure does not lose fetched instructions.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH); pointer width.
- CNT_W, 16, width of the flush performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_pc  in  64  pc_current from IF.
- if_inst  in  32  inst from IF for if_pc.
- if_stall  out  1  to IF stall; holds the PC.
- if_pc_src  out  1  to IF pc_src; selects the redirect target.
- if_b_j_result  out  64  to IF b_j_Result; redirect target.
- ex_redirect  in  1  EX branch/jump taken, or mispredict.
- ex_target  in  64  redirect destination; valid when ex_redirect=1.
- id_valid  out  1  head entry valid.
- id_ready  in  1  ID accepts the head this cycle.
- id_pc  out  64  head PC.
- id_inst  out  32  head instruction.
- flush_cnt  out  CNT_W  number of redirect events since reset; saturates.

Behaviour:
- Reset (asynchronous, active-high): rd_ptr=wr_ptr=0, count=0, warm=0, flush_cnt=0.
  - Outputs during reset: id_valid=0, if_stall=0, if_pc_src=0, id_pc=0, id_inst=0.
- Warm-up: the instruction memory is synchronous, so IF output in the first cycle after reset release is invalid.
  - warm is 0 in that cycle and is set at the following edge.
  - No enqueue while warm=0.
- full = (count==DEPTH); empty = (count==0).
- if_stall = full & ~ex_redirect. Combinational. It must never be 1 while a redirect is requested, otherwise the PC enable would drop the redirect.
- if_pc_src = ex_redirect; if_b_j_result = ex_target. Pure combinational pass-through, zero latency.
- enq = warm & ~full & ~ex_redirect. Every IF presentation without stall is a new fetch.
- deq = id_valid & id_ready & ~ex_redirect.
- id_valid = ~empty. id_pc/id_inst come from the head entry. When empty they hold their last value; they are don't-care and are not checked.
- Normal cycle:
  - on enq, write {if_pc, if_inst} at wr_ptr and wr_ptr++;
  - on deq, rd_ptr++;
  - count += enq - deq.
  - Simultaneous enq and deq leaves count unchanged. Allowed when 0<count<DEPTH.
  - With count==DEPTH, enq is blocked even if deq fires. IF re-presents the same PC next cycle, so nothing is lost.
- Pointers wrap modulo DEPTH (natural PTR_W overflow).
- Flush (ex_redirect=1):
  - at the edge, rd_ptr=wr_ptr=0 and count=0;
  - the IF pair presented in that cycle is discarded (wrong path);
  - no deq is reported to ID;
  - flush_cnt increments unless it is all-ones.
  - The next cycle IF presents ex_target, which is enqueued normally. Queue is empty for exactly one cycle, so latency redirect-to-id_valid = 2 cycles.
- Latency: an enqueued entry is visible on id_valid the cycle after its enq edge (1-cycle fall-through minimum). There is no combinational bypass from if_* to id_*.
- Back-to-back redirects: each one flushes; if_pc_src follows ex_redirect every cycle.
- Reset mid-operation: all entries dropped immediately; warm-up repeats after release.

Decomposition:
- Shared package (cpu_pkg):
  - constants XLEN=64, ILEN=32;
  - typedef fetch_pkt_t {pc[XLEN], inst[ILEN]};
  - constant NOP_INST=32'h00000013.
- Sub-module fetch_queue_mem: DEPTH x fetch_pkt_t register array. Synchronous write port, combinational read port, no reset on the data array.
- Pointers, count, warm, and flush logic stay in the top module.

Test Plan:
- Warm-up / first enqueue: release reset; IF presents pc=0x0 in cycle 1 and 0x4 in cycle 2. The cycle-1 pair is dropped; id_valid rises in cycle 3 with id_pc=0x4. flush_cnt=0.
- Fill: id_ready=0, IF streams 0x4,0x8,0xC,0x10. After 4 enqueues, if_stall=1 and count=4. The 0x14 presentation is not enqueued; id_pc stays 0x4.
- Drain while full: from the full state, id_ready=1 for one cycle. The head advances to 0x8 and if_stall stays 1 that cycle. The next cycle 0x14 is enqueued and the order 0x8,0xC,0x10,0x14 is preserved.
- Redirect while full: ex_redirect=1, ex_target=0x200 while count=4 and id_ready=1.
  - Same cycle: if_stall=0, if_pc_src=1, if_b_j_result=0x200.
  - Next cycle: id_valid=0, flush_cnt=1.
  - Following cycle: id_pc=0x200.
- Wrap: stream 10 sequential PCs with id_ready toggling 1,0,1,... All 10 appear on id_pc exactly once, in order, with no duplicates and no drops.
- Async reset mid-stream: assert reset between edges with count=3. id_valid=0 and if_stall=0 immediately; after release, the warm-up drop repeats.
